// File: rtl/alu_op_sequencer.sv
// Sequencer for the 4-bit ALU: logic ops in place, add/sub/mul through one shared external adder.
// Latency: accept edge to done is 2 edges (5 for multiply); start is ignored while busy or in DONE, no queuing.
module alu_op_sequencer #(
    parameter int MUL_STEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       L,
    input  logic       M,
    input  logic       N,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] addA,
    output logic [3:0] addB,
    output logic       addCin,
    input  logic [3:0] addSum,
    input  logic       addCout,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       zero
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t             state;
    logic [3:0]         aReg;
    logic [3:0]         bReg;
    logic [2:0]         opReg;
    logic [7:0]         prod;
    logic [CNT_W-1:0]   stepCnt;
    logic [7:0]         execRes;
    logic [7:0]         mulNext;

    // Adder ports are purely a function of state, so reset zeroes them immediately.
    always_comb begin
        addA   = 4'h0;
        addB   = 4'h0;
        addCin = 1'b0;
        case (state)
            EXEC: begin
                if (opReg == 3'b011) begin
                    addA = aReg;
                    addB = bReg;
                end else if (opReg == 3'b010) begin
                    addA   = aReg;
                    addB   = ~bReg;
                    addCin = 1'b1;
                end
            end
            MUL: begin
                addA = prod[7:4];
                addB = prod[0] ? aReg : 4'h0;
            end
            default: ;
        endcase
    end

    always_comb begin
        execRes = 8'h00;
        case (opReg)
            3'b000:  execRes = {4'h0, ~aReg};
            3'b001:  execRes = {4'h0, bReg};
            3'b010,
            3'b011:  execRes = {3'b000, addCout, addSum};
            3'b100:  execRes = {4'h0, aReg & bReg};
            3'b101:  execRes = {4'h0, aReg | bReg};
            3'b110:  execRes = {4'h0, aReg ^ bReg};
            default: execRes = result;
        endcase
    end

    // One shift-and-add step: the adder's 5-bit sum becomes the new high part.
    assign mulNext = {addCout, addSum, prod[3:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            aReg    <= 4'h0;
            bReg    <= 4'h0;
            opReg   <= 3'b000;
            prod    <= 8'h00;
            stepCnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 8'h00;
            zero    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        aReg    <= A;
                        bReg    <= B;
                        opReg   <= {L, M, N};
                        prod    <= {4'h0, B};
                        stepCnt <= '0;
                        busy    <= 1'b1;
                        state   <= ({L, M, N} == 3'b111) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    result <= execRes;
                    zero   <= (execRes == 8'h00);
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                MUL: begin
                    prod    <= mulNext;
                    stepCnt <= stepCnt + CNT_W'(1);
                    if (stepCnt == CNT_W'(MUL_STEPS - 1)) begin
                        result <= mulNext;
                        zero   <= (mulNext == 8'h00);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed test of alu_op_sequencer with a behavioural shared adder and a done-driven scoreboard.
module tb_alu_op_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       L, M, N;
    logic [3:0] A, B;
    logic [3:0] addA, addB;
    logic       addCin;
    logic [3:0] addSum;
    logic       addCout;
    logic       busy, done;
    logic [7:0] result;
    logic       zero;

    alu_op_sequencer #(.MUL_STEPS(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .L(L), .M(M), .N(N), .A(A), .B(B),
        .addA(addA), .addB(addB), .addCin(addCin),
        .addSum(addSum), .addCout(addCout),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB} + {4'h0, addCin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       z;
        int         lat;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   doneCount = 0;
    int   expDones = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: latency is counted from the accept edge using busy, compared at each done.
    initial begin
        int   busyCnt = 0;
        logic prevDone = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneCount++;
                chk("donePulseWidth", {31'b0, prevDone}, 32'd0);
                if (expQ.size() == 0) begin
                    chk("unexpectedDone", doneCount, expDones);
                end else begin
                    e = expQ.pop_front();
                    chk("result", {24'b0, result}, {24'b0, e.res});
                    chk("zero", {31'b0, zero}, {31'b0, e.z});
                    chk("latency", busyCnt + 1, e.lat);
                end
                busyCnt = 0;
            end else if (busy === 1'b1) begin
                busyCnt++;
            end else begin
                busyCnt = 0;
            end
            prevDone = done;
        end
    end

    // Leaves the caller at the negedge right after the accept edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input logic [7:0] res, input logic track);
        exp_t e;
        @(negedge clk);
        A = a;
        B = b;
        {L, M, N} = op;
        start = 1'b1;
        if (track) begin
            e.res = res;
            e.z   = (res == 8'h00);
            e.lat = (op == 3'b111) ? 5 : 2;
            expQ.push_back(e);
            expDones++;
        end
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        {L, M, N} = ~op;
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        {L, M, N} = 3'b000;
        A = 4'h0;
        B = 4'h0;
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {24'b0, result}, 32'h00);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        chk("rst_adder", {23'b0, addA, addB, addCin}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(4'd9, 4'd8, 3'b011, 8'h11, 1);
        chk("add_addA", {28'b0, addA}, 32'd9);
        chk("add_addB", {28'b0, addB}, 32'd8);
        chk("add_addCin", {31'b0, addCin}, 32'd0);
        waitDone("add");

        issue(4'd3, 4'd5, 3'b010, 8'h0E, 1);
        chk("sub_addB", {28'b0, addB}, 32'hA);
        chk("sub_addCin", {31'b0, addCin}, 32'd1);
        waitDone("sub_borrow");
        issue(4'd5, 4'd5, 3'b010, 8'h10, 1);
        waitDone("sub_equal");

        issue(4'h5, 4'h3, 3'b000, 8'h0A, 1);
        chk("not_adderIdle", {23'b0, addA, addB, addCin}, 32'd0);
        waitDone("not");
        issue(4'h7, 4'h0, 3'b001, 8'h00, 1);
        waitDone("passB");
        issue(4'hC, 4'hA, 3'b100, 8'h08, 1);
        waitDone("and");
        issue(4'h5, 4'hA, 3'b101, 8'h0F, 1);
        waitDone("or");
        issue(4'hF, 4'hF, 3'b110, 8'h00, 1);
        waitDone("xor");

        // 15x15 with a start pulse (A=1,B=1) during the multiply that must be ignored.
        issue(4'hF, 4'hF, 3'b111, 8'hE1, 1);
        chk("mul15_addB0", {28'b0, addB}, 32'hF);
        chk("mul15_addA0", {28'b0, addA}, 32'h0);
        @(negedge clk);
        chk("mul15_addB1", {28'b0, addB}, 32'hF);
        chk("mul15_addA1", {28'b0, addA}, 32'h7);
        A = 4'd1;
        B = 4'd1;
        {L, M, N} = 3'b111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mul15_addA2", {28'b0, addA}, 32'hB);
        chk("mul15_busy", {31'b0, busy}, 32'd1);
        waitDone("mul15");

        issue(4'd3, 4'd5, 3'b111, 8'h0F, 1);
        chk("mul35_addB0", {28'b0, addB}, 32'd3);
        @(negedge clk);
        chk("mul35_addB1", {28'b0, addB}, 32'd0);
        @(negedge clk);
        chk("mul35_addB2", {28'b0, addB}, 32'd3);
        @(negedge clk);
        chk("mul35_addB3", {28'b0, addB}, 32'd0);
        waitDone("mul35");

        issue(4'd0, 4'd7, 3'b111, 8'h00, 1);
        waitDone("mul0");

        // Abort a multiply after two steps with an asynchronous reset.
        issue(4'd3, 4'd5, 3'b111, 8'h0F, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", {24'b0, result}, 32'h00);
        chk("abort_zero", {31'b0, zero}, 32'd1);
        chk("abort_adder", {23'b0, addA, addB, addCin}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(4'd2, 4'd3, 3'b011, 8'h05, 1);
        waitDone("addAfterAbort");

        repeat (4) @(negedge clk);
        chk("doneCount", doneCount, expDones);
        chk("queueEmpty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL globalTimeout: got running want finished");
        $fatal(1);
    end

endmodule
